// File: rtl/life_announcer.sv
// life_announcer: turns milestone codes from the life-stage FSM into 5-byte ASCII announcements.
// Latency: first byte valid the cycle after the edge that samples a new code; one IDLE cycle between messages.
// Backpressure: out_valid/out_ready handshake; a byte is held until accepted, and newer codes queue as one pending slot.
// Ports: clk, reset (async, active-high); state_in[2:0] milestone code;
//        out_ready from sink; out_valid/out_data[7:0]/out_last byte stream;
//        busy = message in flight; drop_cnt[3:0] saturating count of superseded pending codes.
module life_announcer (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] state_in,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       out_last,
  output logic       busy,
  output logic [3:0] drop_cnt
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  logic [0:0] fsm;
  logic [2:0] cur_state;
  logic [2:0] pend_state;
  logic       pending;
  logic [2:0] idx;

  logic [2:0] target;
  logic       new_ev;

  // Byte i of the announcement for a code; the final byte is always a newline.
  function automatic logic [7:0] msg_byte(input logic [2:0] code, input logic [2:0] i);
    logic [39:0] m;
    logic [7:0]  b;
    case (code)
      3'd0:    m = {"UGRD", 8'h0A};
      3'd1:    m = {"OILG", 8'h0A};
      3'd2:    m = {"MARN", 8'h0A};
      3'd3:    m = {"USA!", 8'h0A};
      3'd4:    m = {"PRDU", 8'h0A};
      3'd5:    m = {"NEXT", 8'h0A};
      default: m = {"????", 8'h0A};
    endcase
    case (i)
      3'd0:    b = m[39:32];
      3'd1:    b = m[31:24];
      3'd2:    b = m[23:16];
      3'd3:    b = m[15:8];
      default: b = m[7:0];
    endcase
    return b;
  endfunction

  // Compare against the code that will be announced next: the pending one if
  // any, else the one in flight. A return to cur_state with nothing pending is
  // therefore not an event.
  assign target = pending ? pend_state : cur_state;
  assign new_ev = (state_in != target);

  assign out_valid = (fsm == SEND);
  assign busy      = (fsm == SEND);
  assign out_data  = out_valid ? msg_byte(cur_state, idx) : 8'h00;
  assign out_last  = out_valid && (idx == 3'd4);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm        <= IDLE;
      cur_state  <= 3'd0;
      pend_state <= 3'd0;
      // Pending out of reset forces an announcement of whatever code is present.
      pending    <= 1'b1;
      idx        <= 3'd0;
      drop_cnt   <= 4'd0;
    end else begin
      case (fsm)
        IDLE: begin
          if (new_ev || pending) begin
            cur_state <= new_ev ? state_in : pend_state;
            pending   <= 1'b0;
            idx       <= 3'd0;
            fsm       <= SEND;
          end
        end
        default: begin
          // Only the newest code is kept; overwriting a live pending slot is a drop.
          if (new_ev) begin
            pend_state <= state_in;
            pending    <= 1'b1;
            if (pending && (drop_cnt != 4'd15)) begin
              drop_cnt <= drop_cnt + 4'd1;
            end
          end
          if (out_ready) begin
            if (idx == 3'd4) begin
              fsm <= IDLE;
            end else begin
              idx <= idx + 3'd1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_life_announcer.sv
// tb_life_announcer: bench for life_announcer.
// Latency: n/a (bench).
// Backpressure: drives out_ready patterns; compares every cycle against a byte-queue model.
module tb_life_announcer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] state_in = 3'd0;
  logic       out_ready = 1'b1;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_last;
  logic       busy;
  logic [3:0] drop_cnt;

  int tests = 0;
  int fails = 0;

  life_announcer dut (
    .clk      (clk),
    .reset    (reset),
    .state_in (state_in),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_last (out_last),
    .busy     (busy),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic string text_of(input int code);
    case (code)
      0:       return "UGRD\n";
      1:       return "OILG\n";
      2:       return "MARN\n";
      3:       return "USA!\n";
      4:       return "PRDU\n";
      5:       return "NEXT\n";
      default: return "????\n";
    endcase
  endfunction

  // Model: bytes still to be sent for the current message, plus at most one
  // waiting code (the latest one requested while a message was in flight).
  logic [7:0] m_q[$];
  bit         m_pend  = 1'b1;
  int         m_pcode = 0;
  int         m_cur   = 0;
  int         m_drop  = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_q.delete();
      m_pend  = 1'b1;
      m_pcode = 0;
      m_cur   = 0;
      m_drop  = 0;
    end else begin
      int    want;
      bit    ev;
      string s;
      want = m_pend ? m_pcode : m_cur;
      ev   = (int'(state_in) != want);
      if (m_q.size() == 0) begin
        if (ev || m_pend) begin
          // Whichever way the start is triggered, the code announced is the one on the input now.
          m_cur  = int'(state_in);
          m_pend = 1'b0;
          s      = text_of(m_cur);
          for (int i = 0; i < 5; i++) m_q.push_back(s[i]);
        end
      end else begin
        if (ev) begin
          if (m_pend && m_drop < 15) m_drop++;
          m_pend  = 1'b1;
          m_pcode = int'(state_in);
        end
        if (out_ready) void'(m_q.pop_front());
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    logic       ev_valid;
    logic [7:0] ev_data;
    ev_valid = (m_q.size() > 0);
    ev_data  = ev_valid ? m_q[0] : 8'h00;
    check("out_valid", 32'(out_valid), 32'(ev_valid));
    check("out_data",  32'(out_data),  32'(ev_data));
    check("out_last",  32'(out_last),  32'(m_q.size() == 1));
    check("busy",      32'(busy),      32'(ev_valid));
    check("drop_cnt",  32'(drop_cnt),  32'(m_drop));
  end

  // Log of bytes actually handed over to the sink.
  logic [7:0] accepted[$];
  always @(negedge clk) begin
    if (!reset && out_valid === 1'b1 && out_ready) accepted.push_back(out_data);
  end

  task automatic check_bytes(input string name, input string s);
    check({name, "_len"}, 32'(accepted.size()), 32'(s.len()));
    for (int i = 0; i < s.len(); i++) begin
      if (i < accepted.size()) check({name, "_byte"}, 32'(accepted[i]), 32'(s[i]));
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  bit pat[14] = '{1, 0, 0, 1, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1};

  initial begin
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    accepted.delete();
    reset = 1'b0;

    // Start-up announcement of code 0.
    repeat (8) tick();
    check_bytes("ugrd", "UGRD\n");
    check("ugrd_idle_valid", 32'(out_valid), 32'd0);
    check("ugrd_idle_busy",  32'(busy),      32'd0);

    // 0 -> 3 from idle: first byte one cycle later.
    state_in = 3'd3;
    @(posedge clk);
    @(negedge clk);
    check("usa_first_valid", 32'(out_valid), 32'd1);
    check("usa_first_data",  32'(out_data),  32'h55);
    check("usa_drop",        32'(drop_cnt),  32'd0);
    repeat (8) tick();

    // Backpressure during "OILG\n".
    accepted.delete();
    state_in = 3'd1;
    for (int i = 0; i < 14; i++) begin
      tick();
      out_ready = pat[i];
    end
    out_ready = 1'b1;
    repeat (3) tick();
    check_bytes("oilg", "OILG\n");

    // Supersedes during a message for 1: only PRDU follows.
    state_in = 3'd0;
    repeat (8) tick();
    accepted.delete();
    state_in = 3'd1;
    tick();
    state_in = 3'd2;
    tick();
    state_in = 3'd3;
    tick();
    state_in = 3'd4;
    repeat (12) tick();
    check_bytes("supersede", "OILG\nPRDU\n");
    check("supersede_drop", 32'(drop_cnt), 32'd2);

    // Invalid code, then saturation of the drop counter.
    accepted.delete();
    state_in = 3'd7;
    repeat (8) tick();
    check_bytes("invalid7", "????\n");
    out_ready = 1'b0;
    state_in  = 3'd0;
    tick();
    for (int i = 0; i < 20; i++) begin
      state_in = (i % 2 == 1) ? 3'd5 : 3'd6;
      tick();
    end
    check("drop_sat", 32'(drop_cnt), 32'd15);
    out_ready = 1'b1;
    repeat (14) tick();
    check("drop_sat_hold", 32'(drop_cnt), 32'd15);

    // Reset in the middle of "MARN\n".
    state_in = 3'd2;
    repeat (3) tick();
    @(negedge clk);
    check("marn_byte2", 32'(out_data), 32'h52);
    #1 reset = 1'b1;
    #1;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_busy",  32'(busy),      32'd0);
    check("rst_data",  32'(out_data),  32'd0);
    check("rst_drop",  32'(drop_cnt),  32'd0);
    @(posedge clk);
    tick();
    accepted.delete();
    reset = 1'b0;
    repeat (8) tick();
    check_bytes("after_reset", "MARN\n");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
